// File: rtl/proc_pkg.sv
// Shared encodings for the multicycle bus processor: opcodes, step
// counter states, bus-source selects and ALU operations.
package proc_pkg;

    // Instruction opcodes (IR[IRW-1 -: 3])
    localparam logic [2:0] OP_MV   = 3'd0;
    localparam logic [2:0] OP_MVI  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_OR   = 3'd5;
    localparam logic [2:0] OP_MVNZ = 3'd6;
    localparam logic [2:0] OP_XOR  = 3'd7;

    // Step counter walks T0..T3
    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_t;

    // Sources that may drive the shared bus
    typedef enum logic [1:0] {
        SEL_DIN = 2'd0,
        SEL_G   = 2'd1,
        SEL_RX  = 2'd2,
        SEL_RY  = 2'd3
    } bus_sel_t;

    // Operations the ALU can perform
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4
    } alu_op_t;

    // Map an instruction opcode onto its ALU operation; non-ALU opcodes
    // fall back to ADD, which is harmless because G is not loaded for them.
    function automatic alu_op_t alu_op_of(input logic [2:0] op);
        alu_op_t r;
        case (op)
            OP_SUB:  r = ALU_SUB;
            OP_AND:  r = ALU_AND;
            OP_OR:   r = ALU_OR;
            OP_XOR:  r = ALU_XOR;
            default: r = ALU_ADD;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/proc_alu.sv
// Purely combinational ALU. Arithmetic is done one bit wider than the
// datapath so the top bit is the carry (ADD) or the no-borrow (SUB).
module proc_alu
    import proc_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  alu_op_t       aluop,
    output logic [DW-1:0] result,
    output logic          carry,
    output logic          zero
);

    logic [DW:0] wide;

    // Evaluate the selected operation; logic ops always report carry 0
    always_comb begin
        wide = '0;
        case (aluop)
            ALU_ADD: wide = {1'b0, a} + {1'b0, b};
            ALU_SUB: wide = {1'b0, a} + {1'b0, ~b} + (DW+1)'(1);
            ALU_AND: wide = {1'b0, a & b};
            ALU_OR:  wide = {1'b0, a | b};
            ALU_XOR: wide = {1'b0, a ^ b};
            default: wide = '0;
        endcase
    end

    assign result = wide[DW-1:0];
    assign carry  = wide[DW];
    assign zero   = (wide[DW-1:0] == '0);

endmodule

// File: rtl/proc_multicycle_param.sv
// Parametrised multicycle bus processor: NREG general registers on one
// shared bus, A/G ALU registers, Z/C flags and a T0..T3 step counter.
// Instructions arrive on DIN under Run; Done marks the retiring cycle.
module proc_multicycle_param
    import proc_pkg::*;
#(
    parameter int DW   = 16,
    parameter int NREG = 8
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          Run,
    input  logic [DW-1:0] DIN,
    output logic          Done,
    output logic [DW-1:0] BusWires,
    output logic          Zflag,
    output logic          Cflag
);

    localparam int RAW = $clog2(NREG);
    localparam int IRW = 3 + 2*RAW;

    step_t           step_q, step_d;
    logic [IRW-1:0]  ir_q, ir_d;
    logic [DW-1:0]   a_q, a_d;
    logic [DW-1:0]   g_q, g_d;
    logic            z_q, z_d;
    logic            c_q, c_d;
    logic [DW-1:0]   r_q [NREG];
    logic [DW-1:0]   r_d [NREG];

    logic            ir_in, a_in, g_in, rx_we, done;
    bus_sel_t        bus_sel;
    logic [DW-1:0]   bus;

    logic [2:0]      op;
    logic [RAW-1:0]  rx_idx, ry_idx;
    alu_op_t         aluop;
    logic [DW-1:0]   alu_result;
    logic            alu_carry, alu_zero;

    assign op     = ir_q[IRW-1 -: 3];
    assign rx_idx = ir_q[2*RAW-1 -: RAW];
    assign ry_idx = ir_q[RAW-1:0];
    assign aluop  = alu_op_of(op);

    // Step counter register; reset aborts any instruction in flight
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            step_q <= T0;
        end else begin
            step_q <= step_d;
        end
    end

    // Control decode: next step plus the per-cycle enables and bus select.
    // At most one register enable is raised in any step.
    always_comb begin
        step_d  = step_q;
        ir_in   = 1'b0;
        a_in    = 1'b0;
        g_in    = 1'b0;
        rx_we   = 1'b0;
        done    = 1'b0;
        bus_sel = SEL_DIN;
        case (step_q)
            T0: begin
                if (Run) begin
                    ir_in  = 1'b1;
                    step_d = T1;
                end
            end
            T1: begin
                case (op)
                    OP_MV: begin
                        bus_sel = SEL_RY;
                        rx_we   = 1'b1;
                        done    = 1'b1;
                    end
                    OP_MVI: begin
                        bus_sel = SEL_DIN;
                        rx_we   = 1'b1;
                        done    = 1'b1;
                    end
                    OP_MVNZ: begin
                        bus_sel = SEL_RY;
                        rx_we   = ~z_q;
                        done    = 1'b1;
                    end
                    default: begin
                        bus_sel = SEL_RX;
                        a_in    = 1'b1;
                        step_d  = T2;
                    end
                endcase
            end
            T2: begin
                bus_sel = SEL_RY;
                g_in    = 1'b1;
                step_d  = T3;
            end
            T3: begin
                bus_sel = SEL_G;
                rx_we   = 1'b1;
                done    = 1'b1;
            end
            default: begin
                step_d = T0;
            end
        endcase
        if (done) begin
            step_d = T0;
        end
    end

    // Shared bus: registers are picked by binary index straight from IR
    always_comb begin
        case (bus_sel)
            SEL_RX:  bus = r_q[rx_idx];
            SEL_RY:  bus = r_q[ry_idx];
            SEL_G:   bus = g_q;
            default: bus = DIN;
        endcase
    end

    proc_alu #(
        .DW (DW)
    ) u_alu (
        .a      (a_q),
        .b      (bus),
        .aluop  (aluop),
        .result (alu_result),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

    // Next values for IR, A, G and the flags; flags move only with G
    always_comb begin
        ir_d = ir_in ? DIN[DW-1 -: IRW] : ir_q;
        a_d  = a_in  ? bus : a_q;
        g_d  = g_in  ? alu_result : g_q;
        z_d  = g_in  ? alu_zero   : z_q;
        c_d  = g_in  ? alu_carry  : c_q;
    end

    // IR, A, G and flag registers
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            ir_q <= '0;
            a_q  <= '0;
            g_q  <= '0;
            z_q  <= 1'b0;
            c_q  <= 1'b0;
        end else begin
            ir_q <= ir_d;
            a_q  <= a_d;
            g_q  <= g_d;
            z_q  <= z_d;
            c_q  <= c_d;
        end
    end

    // General register file, one write port addressed by Rx
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
        // Load from the bus when this register is the Rx target
        always_comb begin
            r_d[gi] = (rx_we && (rx_idx == RAW'(gi))) ? bus : r_q[gi];
        end

        // Register storage
        always_ff @(posedge Clock or negedge Resetn) begin
            if (!Resetn) begin
                r_q[gi] <= '0;
            end else begin
                r_q[gi] <= r_d[gi];
            end
        end
    end

    assign Done     = done;
    assign BusWires = bus;
    assign Zflag    = z_q;
    assign Cflag    = c_q;

endmodule

// File: tb/tb_proc_multicycle_param.sv
// Bench for proc_multicycle_param: a 16-bit/8-register core and an
// 8-bit/4-register core share clock and reset. Each issued instruction
// pushes its expected bus value and flags at Done; monitors pop and check.
module tb_proc_multicycle_param;
    import proc_pkg::*;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic        run_a, run_b;
    logic [15:0] din_a, bus_a;
    logic [7:0]  din_b, bus_b;
    logic        done_a, z_a, c_a;
    logic        done_b, z_b, c_b;

    typedef struct packed {
        logic [31:0] id;
        logic [15:0] bus;
        logic        z;
        logic        c;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   total = 0;
    int   bad   = 0;
    int   txn   = 0;

    proc_multicycle_param #(.DW(16), .NREG(8)) dut_a (
        .Clock(Clock), .Resetn(Resetn), .Run(run_a), .DIN(din_a),
        .Done(done_a), .BusWires(bus_a), .Zflag(z_a), .Cflag(c_a)
    );

    proc_multicycle_param #(.DW(8), .NREG(4)) dut_b (
        .Clock(Clock), .Resetn(Resetn), .Run(run_b), .DIN(din_b),
        .Done(done_b), .BusWires(bus_b), .Zflag(z_b), .Cflag(c_b)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Pop the oldest expectation for the given core and compare
    task automatic mon(input int sel, input logic [15:0] gb, input logic gz, input logic gc);
        exp_t e;
        total++;
        if ((sel == 0 && q_a.size() == 0) || (sel == 1 && q_b.size() == 0)) begin
            bad++;
            $display("FAIL unexpected_done dut%0d got bus=%h want no Done", sel, gb);
        end else begin
            e = (sel == 0) ? q_a.pop_front() : q_b.pop_front();
            if (gb !== e.bus || gz !== e.z || gc !== e.c) begin
                bad++;
                $display("FAIL txn%0d dut%0d got bus=%h z=%b c=%b want bus=%h z=%b c=%b",
                         e.id, sel, gb, gz, gc, e.bus, e.z, e.c);
            end else begin
                $display("txn %0d dut%0d bus=%h z=%b c=%b ok", e.id, sel, gb, gz, gc);
            end
        end
    endtask

    always @(negedge Clock) begin
        if (Resetn === 1'b1 && done_a === 1'b1) mon(0, bus_a, z_a, c_a);
    end

    always @(negedge Clock) begin
        if (Resetn === 1'b1 && done_b === 1'b1) mon(1, {8'h00, bus_b}, z_b, c_b);
    end

    // Issue one instruction, push its expectation, wait (bounded) for Done
    task automatic exec(input int sel, input logic [2:0] op, input int x, input int y,
                        input logic [15:0] imm, input logic [15:0] exp_bus,
                        input logic ez, input logic ec, input int ncyc);
        exp_t        e;
        int          cyc;
        logic [15:0] w;
        logic        dn;
        txn++;
        e.id  = txn;
        e.bus = exp_bus;
        e.z   = ez;
        e.c   = ec;
        if (sel == 0) begin
            w = {op, 3'(x), 3'(y), 7'b0};
            q_a.push_back(e);
        end else begin
            w = {8'h00, op, 2'(x), 2'(y), 1'b0};
            q_b.push_back(e);
        end
        @(posedge Clock); #2;
        if (sel == 0) begin run_a = 1'b1; din_a = w; end
        else          begin run_b = 1'b1; din_b = w[7:0]; end
        cyc = 1;
        @(posedge Clock); #2;
        if (sel == 0) begin run_a = 1'b0; din_a = imm; end
        else          begin run_b = 1'b0; din_b = imm[7:0]; end
        cyc = 2;
        dn = (sel == 0) ? done_a : done_b;
        while (!dn && cyc < 8) begin
            @(posedge Clock); #2;
            cyc++;
            dn = (sel == 0) ? done_a : done_b;
        end
        total++;
        if (!dn || cyc != ncyc) begin
            bad++;
            $display("FAIL latency txn%0d got %0d cycles done=%b want %0d cycles", txn, cyc, dn, ncyc);
        end
    endtask

    initial begin
        Resetn = 1'b0;
        run_a  = 1'b0;
        run_b  = 1'b0;
        din_a  = 16'h1234;
        din_b  = 8'h5A;
        #3;
        chk("rst_done_a", {15'h0, done_a}, 16'h0);
        chk("rst_bus_a",  bus_a, 16'h1234);
        chk("rst_flags_a", {14'h0, z_a, c_a}, 16'h0);
        chk("rst_done_b", {15'h0, done_b}, 16'h0);
        chk("rst_bus_b",  {8'h0, bus_b}, 16'h005A);
        @(posedge Clock); #2;
        Resetn = 1'b1;

        // Registers start at zero
        exec(0, OP_MV,   7, 0, 16'h0000, 16'h0000, 1'b0, 1'b0, 2);
        // Immediate loads, then ALU ops
        exec(0, OP_MVI,  0, 0, 16'h0005, 16'h0005, 1'b0, 1'b0, 2);
        exec(0, OP_MVI,  1, 0, 16'h0003, 16'h0003, 1'b0, 1'b0, 2);
        exec(0, OP_ADD,  0, 1, 16'h0000, 16'h0008, 1'b0, 1'b0, 4);
        exec(0, OP_SUB,  1, 1, 16'h0000, 16'h0000, 1'b1, 1'b1, 4);
        // Wrap-around add and MVNZ with Z set (no write)
        exec(0, OP_MVI,  2, 0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 2);
        exec(0, OP_MVI,  3, 0, 16'h0001, 16'h0001, 1'b1, 1'b1, 2);
        exec(0, OP_MVI,  4, 0, 16'h0077, 16'h0077, 1'b1, 1'b1, 2);
        exec(0, OP_ADD,  2, 3, 16'h0000, 16'h0000, 1'b1, 1'b1, 4);
        exec(0, OP_MVNZ, 4, 3, 16'h0000, 16'h0001, 1'b1, 1'b1, 2);
        exec(0, OP_MV,   7, 4, 16'h0000, 16'h0077, 1'b1, 1'b1, 2);
        // Logic ops clear carry
        exec(0, OP_MVI,  5, 0, 16'h00F0, 16'h00F0, 1'b1, 1'b1, 2);
        exec(0, OP_MVI,  6, 0, 16'h0FF0, 16'h0FF0, 1'b1, 1'b1, 2);
        exec(0, OP_AND,  5, 6, 16'h0000, 16'h00F0, 1'b0, 1'b0, 4);
        exec(0, OP_OR,   5, 6, 16'h0000, 16'h0FF0, 1'b0, 1'b0, 4);
        exec(0, OP_MVI,  7, 0, 16'h00F0, 16'h00F0, 1'b0, 1'b0, 2);
        exec(0, OP_XOR,  7, 6, 16'h0000, 16'h0F00, 1'b0, 1'b0, 4);
        // MVNZ with Z clear writes
        exec(0, OP_MVNZ, 0, 7, 16'h0000, 16'h0F00, 1'b0, 1'b0, 2);
        exec(0, OP_MV,   1, 0, 16'h0000, 16'h0F00, 1'b0, 1'b0, 2);
        // Subtract with borrow, then doubling via X == Y
        exec(0, OP_MVI,  2, 0, 16'h0002, 16'h0002, 1'b0, 1'b0, 2);
        exec(0, OP_MVI,  3, 0, 16'h0003, 16'h0003, 1'b0, 1'b0, 2);
        exec(0, OP_SUB,  2, 3, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 4);
        exec(0, OP_ADD,  1, 1, 16'h0000, 16'h1E00, 1'b0, 1'b0, 4);

        // Idle in T0 with Run low and instruction-like DIN
        for (int i = 0; i < 5; i++) begin
            @(posedge Clock); #2;
            din_a = 16'hA000 + 16'(i * 16'h1111);
            #1;
            chk("idle_done", {15'h0, done_a}, 16'h0);
            chk("idle_bus", bus_a, din_a);
        end
        exec(0, OP_MV,   6, 5, 16'h0000, 16'h0FF0, 1'b0, 1'b0, 2);

        // Set both flags, then abort an ADD in T2 with reset
        exec(0, OP_SUB,  1, 1, 16'h0000, 16'h0000, 1'b1, 1'b1, 4);
        @(posedge Clock); #2;
        run_a = 1'b1;
        din_a = {OP_ADD, 3'd5, 3'd6, 7'b0};
        @(posedge Clock); #2;
        run_a = 1'b0;
        @(posedge Clock); #2;
        Resetn = 1'b0;
        din_a  = 16'hBEEF;
        #1;
        chk("abort_done", {15'h0, done_a}, 16'h0);
        chk("abort_flags", {14'h0, z_a, c_a}, 16'h0);
        chk("abort_bus", bus_a, 16'hBEEF);
        @(posedge Clock); #2;
        Resetn = 1'b1;
        exec(0, OP_MV,   7, 6, 16'h0000, 16'h0000, 1'b0, 1'b0, 2);
        exec(0, OP_MV,   7, 5, 16'h0000, 16'h0000, 1'b0, 1'b0, 2);
        exec(0, OP_MVI,  0, 0, 16'h0009, 16'h0009, 1'b0, 1'b0, 2);
        exec(0, OP_ADD,  0, 0, 16'h0000, 16'h0012, 1'b0, 1'b0, 4);

        // Narrow build: DW=8, NREG=4, IR in DIN[7:1]
        exec(1, OP_MV,   3, 2, 16'h0000, 16'h0000, 1'b0, 1'b0, 2);
        exec(1, OP_MVI,  0, 0, 16'h00C8, 16'h00C8, 1'b0, 1'b0, 2);
        exec(1, OP_MVI,  1, 0, 16'h0040, 16'h0040, 1'b0, 1'b0, 2);
        exec(1, OP_ADD,  0, 1, 16'h0000, 16'h0008, 1'b0, 1'b1, 4);
        exec(1, OP_MV,   3, 0, 16'h0000, 16'h0008, 1'b0, 1'b1, 2);
        exec(1, OP_SUB,  1, 1, 16'h0000, 16'h0000, 1'b1, 1'b1, 4);
        exec(1, OP_MVNZ, 2, 0, 16'h0000, 16'h0008, 1'b1, 1'b1, 2);
        exec(1, OP_MV,   3, 2, 16'h0000, 16'h0000, 1'b1, 1'b1, 2);
        exec(1, OP_XOR,  0, 0, 16'h0000, 16'h0000, 1'b1, 1'b0, 4);

        repeat (3) @(posedge Clock);
        #2;
        chk("queue_drained", 16'(q_a.size() + q_b.size()), 16'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
